// File: rtl/seq_mag_comparator.sv
// ---------------------------------------------------------------------------
// seq_mag_comparator
// Multi-cycle magnitude comparator. Compares two WIDTH-bit operands one
// DIGIT-bit slice per clock, most-significant slice first, and stops at the
// first slice that differs. Signed mode maps both operands to offset binary
// so that a plain unsigned slice compare yields the two's-complement order.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only when idle
//   signed_mode  1 = two's-complement compare, sampled with start
//   a, b         operands, sampled with start
//   busy         high while a comparison is running
//   done         one-cycle pulse, result flags valid
//   a_eq_b       A == B
//   a_gt_b       A >  B
//   a_lt_b       A <  B
// ---------------------------------------------------------------------------
module seq_mag_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [IDXW-1:0]   r_idx;
  logic              r_done;
  logic              r_eq;
  logic              r_gt;
  logic              r_lt;

  state_t            w_state_nxt;
  logic [WIDTH-1:0]  w_a_nxt;
  logic [WIDTH-1:0]  w_b_nxt;
  logic [IDXW-1:0]   w_idx_nxt;
  logic              w_done_nxt;
  logic              w_eq_nxt;
  logic              w_gt_nxt;
  logic              w_lt_nxt;
  logic [DIGIT-1:0]  w_slice_a;
  logic [DIGIT-1:0]  w_slice_b;

  // Current slice of the captured operands
  assign w_slice_a = DIGIT'(r_a >> (32'(r_idx) * DIGIT));
  assign w_slice_b = DIGIT'(r_b >> (32'(r_idx) * DIGIT));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      r_eq    <= w_eq_nxt;
      r_gt    <= w_gt_nxt;
      r_lt    <= w_lt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_eq_nxt    = r_eq;
    w_gt_nxt    = r_gt;
    w_lt_nxt    = r_lt;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          // Flipping the sign bit turns signed order into unsigned order
          w_a_nxt     = signed_mode ? (a ^ SIGN_BIT) : a;
          w_b_nxt     = signed_mode ? (b ^ SIGN_BIT) : b;
          w_eq_nxt    = 1'b0;
          w_gt_nxt    = 1'b0;
          w_lt_nxt    = 1'b0;
          w_idx_nxt   = IDXW'(NDIG - 1);
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_slice_a != w_slice_b) begin
          w_gt_nxt    = (w_slice_a > w_slice_b);
          w_lt_nxt    = (w_slice_a < w_slice_b);
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_idx == '0) begin
          w_eq_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt   = r_idx - IDXW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign a_eq_b = r_eq;
  assign a_gt_b = r_gt;
  assign a_lt_b = r_lt;

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
Parametrised, multi-cycle successor to the team's 4-bit combinational magnitude comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per clock, most-significant slice first. It stops as soon as a slice differs and supports unsigned or two's-complement signed comparison. It sits in datapaths where a wide single-cycle compare would break timing; a start/done handshake hands the result to the control FSM.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits compared per clock cycle; 1 <= DIGIT <= WIDTH.
- NDIG (derived, localparam), WIDTH/DIGIT, number of slices.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a comparison is running.
- done  output  1  one-cycle pulse; result flags are valid.
- a_eq_b  output  1  A == B.
- a_gt_b  output  1  A > B.
- a_lt_b  output  1  A < B.

Behaviour:
- Only one clock exists; reset is asynchronous and active-low. rst_n low forces IDLE, and busy, done and all three flags go to 0 immediately, without waiting for a clock edge.
- Two-state FSM: IDLE and RUN. A slice index register idx holds log2(NDIG) bits, minimum 1.
- IDLE, with start=1 at a clock edge:
  - capture a and b into internal registers; if signed_mode=1, invert bit WIDTH-1 of both copies (offset-binary mapping, so an unsigned compare gives the signed order);
  - clear all three flags to 0;
  - set idx = NDIG-1 and go to RUN; busy goes to 1.
- RUN, each cycle: compare slice idx of the captured A and B as unsigned DIGIT-bit values (combinational). At the next edge:
  - slices differ: set a_gt_b or a_lt_b, pulse done, go to IDLE, busy goes to 0;
  - slices equal and idx == 0: set a_eq_b, pulse done, go to IDLE;
  - slices equal and idx > 0: idx decrements, stay in RUN.
- Latency: done rises on edge L after the start-sampling edge. L is the 1-based position, counted from the MSB, of the first differing slice, or NDIG if all slices are equal. Best case is 1 cycle, worst case NDIG cycles.
- done is high for exactly one cycle. At the edge where done rises, exactly one flag becomes 1. The flags hold until the next accepted start or a reset.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt the operation in progress. Changes on a, b or signed_mode during RUN have no effect.
- Back-to-back operation: start high during the done cycle is accepted, because the FSM is already in IDLE. That edge clears the flags and begins the new compare, so there are no idle bubbles.
- Reset mid-RUN: the operation is abandoned, done does not pulse, and the outputs return to 0.
- WIDTH == DIGIT degenerates to a registered single-cycle compare with L = 1.

Test Plan:
1. WIDTH=16, DIGIT=4, unsigned, a=0x1234, b=0x1234 -> busy for 4 cycles, done on edge 4, a_eq_b=1 and the other flags 0, flags held afterwards.
2. Unsigned, a=0x8000, b=0x7FFF -> done on edge 1, a_gt_b=1. Same operands with signed_mode=1 -> done on edge 1, a_lt_b=1.
3. Unsigned, a=0x1235, b=0x1234 -> a_gt_b=1 at L=4. a=0x1204, b=0x1234 -> a_lt_b=1 at L=3.
4. Pulse start again while busy with different operands -> ignored, original result reported. Assert start during the done cycle -> new compare accepted, flags read 0 until the new done.
5. Drop rst_n during RUN with idx=1 -> busy, done and flags go to 0 asynchronously, no done pulse. After release, a new start works normally.
6. Random regression, 10k vectors, for (16,4), (8,1) and (12,12) in both modes, checked against a reference model for flags and exact L; check that done is one-hot in time and the flags are one-hot.
